// File: rtl/spi_ram_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : spi_ram_arbiter
// Brief   : Runs RAM accesses from SPI frames and round-robins them with a
//           local host port onto one single-port synchronous RAM.
// Revision: 1.0
// ---------------------------------------------------------------------------
module spi_ram_arbiter #(
   parameter int ADDR_WIDTH = 8,
   parameter int TX_HOLD    = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [9:0]            rx_data,
   input  logic                  rx_valid,
   output logic [7:0]            tx_data,
   output logic                  tx_valid,
   input  logic                  host_req,
   input  logic                  host_we,
   input  logic [ADDR_WIDTH-1:0] host_addr,
   input  logic [7:0]            host_wdata,
   output logic                  host_gnt,
   output logic [7:0]            host_rdata,
   output logic                  host_rvalid,
   output logic                  mem_en,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [7:0]            mem_wdata,
   input  logic [7:0]            mem_rdata,
   output logic                  spi_drop
);

   localparam int               CNT_W         = (TX_HOLD > 1) ? $clog2(TX_HOLD) : 1;
   localparam logic [CNT_W-1:0] C_HOLD_RELOAD = CNT_W'(TX_HOLD - 1);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCESS = 2'd1;
   localparam logic [1:0] ST_RESP   = 2'd2;

   logic [1:0]            r_state;
   logic                  r_rx_prev;
   logic [ADDR_WIDTH-1:0] r_wr_addr;
   logic [ADDR_WIDTH-1:0] r_rd_addr;
   logic                  r_pend_valid;
   logic                  r_pend_we;
   logic [ADDR_WIDTH-1:0] r_pend_addr;
   logic [7:0]            r_pend_data;
   logic                  r_cur_spi;
   logic                  r_cur_we;
   logic                  r_last_host;
   logic [CNT_W-1:0]      r_tx_cnt;

   logic [ADDR_WIDTH-1:0] w_payload_addr;
   logic                  w_accept;
   logic                  w_spi_busy;
   logic                  w_spi_wins;

   generate
      if (ADDR_WIDTH > 8) begin : g_addr_zext
         assign w_payload_addr = {{(ADDR_WIDTH-8){1'b0}}, rx_data[7:0]};
      end else begin : g_addr_trunc
         assign w_payload_addr = rx_data[ADDR_WIDTH-1:0];
      end
   endgenerate

   assign w_accept   = rx_valid & ~r_rx_prev;
   // An SPI op is still owned by the SPI side until its access (and response) finishes.
   assign w_spi_busy = r_pend_valid | ((r_state != ST_IDLE) & r_cur_spi);
   assign w_spi_wins = r_pend_valid & (~host_req | r_last_host);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_rx_prev    <= 1'b0;
         r_wr_addr    <= '0;
         r_rd_addr    <= '0;
         r_pend_valid <= 1'b0;
         r_pend_we    <= 1'b0;
         r_pend_addr  <= '0;
         r_pend_data  <= '0;
         r_cur_spi    <= 1'b0;
         r_cur_we     <= 1'b0;
         r_last_host  <= 1'b1;
         r_tx_cnt     <= '0;
         tx_data      <= '0;
         tx_valid     <= 1'b0;
         host_gnt     <= 1'b0;
         host_rdata   <= '0;
         host_rvalid  <= 1'b0;
         mem_en       <= 1'b0;
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         spi_drop     <= 1'b0;
      end else begin
         r_rx_prev   <= rx_valid;
         host_rvalid <= 1'b0;

         if (w_accept) begin
            case (rx_data[9:8])
               2'b00: r_wr_addr <= w_payload_addr;
               2'b10: r_rd_addr <= w_payload_addr;
               default: begin
                  if (w_spi_busy) begin
                     spi_drop <= 1'b1;
                  end else begin
                     r_pend_valid <= 1'b1;
                     r_pend_we    <= ~rx_data[9];
                     r_pend_addr  <= rx_data[9] ? r_rd_addr : r_wr_addr;
                     r_pend_data  <= rx_data[7:0];
                  end
               end
            endcase
         end

         if (tx_valid) begin
            if (r_tx_cnt == '0) begin
               tx_valid <= 1'b0;
            end else begin
               r_tx_cnt <= r_tx_cnt - CNT_W'(1);
            end
         end

         case (r_state)
            ST_IDLE: begin
               if (w_spi_wins) begin
                  r_pend_valid <= 1'b0;
                  r_cur_spi    <= 1'b1;
                  r_cur_we     <= r_pend_we;
                  r_last_host  <= 1'b0;
                  mem_en       <= 1'b1;
                  mem_we       <= r_pend_we;
                  mem_addr     <= r_pend_addr;
                  mem_wdata    <= r_pend_data;
                  r_state      <= ST_ACCESS;
               end else if (host_req) begin
                  r_cur_spi    <= 1'b0;
                  r_cur_we     <= host_we;
                  r_last_host  <= 1'b1;
                  host_gnt     <= 1'b1;
                  mem_en       <= 1'b1;
                  mem_we       <= host_we;
                  mem_addr     <= host_addr;
                  mem_wdata    <= host_wdata;
                  r_state      <= ST_ACCESS;
               end
            end
            ST_ACCESS: begin
               mem_en   <= 1'b0;
               mem_we   <= 1'b0;
               host_gnt <= 1'b0;
               r_state  <= r_cur_we ? ST_IDLE : ST_RESP;
            end
            ST_RESP: begin
               // A new SPI result overrides any hold still in progress.
               if (r_cur_spi) begin
                  tx_data  <= mem_rdata;
                  tx_valid <= 1'b1;
                  r_tx_cnt <= C_HOLD_RELOAD;
               end else begin
                  host_rdata  <= mem_rdata;
                  host_rvalid <= 1'b1;
               end
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire
